// File: rtl/text_overlay_anim.sv
// text_overlay_anim: animated NUM_LINES x LINE_LEN text overlay (static, fall, reveal, blink) over VGA.
// Define TEXT_OVERLAY_SHADOW_EN to add a drop shadow offset by (SCALE, SCALE).
module text_overlay_anim #(
  parameter int NUM_LINES = 2,
  parameter int LINE_LEN = 12,
  parameter int SCALE = 2,
  parameter int LINE_GAP = 4,
  parameter int TEXT_X = 224,
  parameter int TARGET_Y = 336,
  parameter int FALL_STEP = 4,
  parameter int REVEAL_FRAMES = 4,
  parameter int BLINK_FRAMES = 30,
  parameter logic [5:0] TEXT_COLOR = 6'b111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       next_frame,
  input  logic       wr_en,
  input  logic [1:0] wr_line,
  input  logic [3:0] wr_col,
  input  logic [4:0] wr_char,
  input  logic [1:0] mode,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       draw,
  output logic [5:0] rgb
);
  localparam int CH = 8 * SCALE;
  localparam int PITCH = CH + LINE_GAP;
  localparam int TOTAL = NUM_LINES * LINE_LEN;
  localparam int SH = $clog2(SCALE);
  localparam int IW = TOTAL > 1 ? $clog2(TOTAL) : 1;
  localparam int RW = $clog2(TOTAL + 1);
  localparam int FMAX = REVEAL_FRAMES > BLINK_FRAMES ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int FW = $clog2(FMAX + 1);
  localparam logic [5:0] TEXT_RGB = {TEXT_COLOR[5], TEXT_COLOR[3], TEXT_COLOR[1],
                                     TEXT_COLOR[4], TEXT_COLOR[2], TEXT_COLOR[0]};

  typedef enum logic [1:0] {IDLE, FALL, REVEAL, BLINK} state_t;

  state_t state, state_n;
  logic [4:0] chars [TOTAL];
  logic [9:0] base_y, base_y_n;
  logic [RW-1:0] reveal_cnt, reveal_n;
  logic [FW-1:0] frame_cnt, frame_n;
  logic visible, visible_n, done_n, wrap, text_on, pix_on;
  logic [10:0] step;
  logic [5:0] pix_rgb;

  // glyph rows packed MSB-first, leftmost pixel in the top bit of each row
  function automatic logic [63:0] glyph(input logic [4:0] c);
    case (c)
      5'd1:    glyph = 64'hC6C6C6D6FEEEC600;
      5'd2:    glyph = 64'h386CC6FEC6C6C600;
      5'd3:    glyph = 64'h7E18181818181800;
      5'd4:    glyph = 64'hFEC0C0FCC0C0FE00;
      5'd5:    glyph = 64'hFCC6C6FCD8CCC600;
      5'd6:    glyph = 64'hC0C0C0C0C0C0FE00;
      5'd7:    glyph = 64'h7CC6C6C6C6C67C00;
      5'd8:    glyph = 64'hC6E6F6DECEC6C600;
      5'd9:    glyph = 64'h7CC6C0CEC6C67E00;
      5'd10:   glyph = 64'h7E18181818187E00;
      default: glyph = 64'h0;
    endcase
  endfunction

  function automatic logic lit(input logic [10:0] px, input logic [10:0] py);
    logic [10:0] xo, yo, top;
    logic [63:0] g;
    int idx;
    lit = 1'b0;
    xo = px - 11'(TEXT_X);
    for (int k = 0; k < NUM_LINES; k++) begin
      top = {1'b0, base_y} + 11'(k * PITCH);
      yo = py - top;
      idx = k * LINE_LEN + int'(xo >> (SH + 3));
      if (px >= 11'(TEXT_X) && int'(xo) < LINE_LEN * CH && py >= top && int'(yo) < CH &&
          int'(top) <= 1024 - CH && idx < int'(reveal_cnt)) begin
        g = glyph(chars[IW'(idx)]);
        lit = g[{~yo[SH+2:SH], ~xo[SH+2:SH]}];
      end
    end
  endfunction

`ifdef TEXT_OVERLAY_SHADOW_EN
  localparam logic [5:0] SHADOW_RGB = 6'b000111;
  logic shadow_on;
  always_comb begin
    text_on = active && visible && lit({1'b0, x}, {1'b0, y});
    shadow_on = active && visible && !text_on && lit({1'b0, x} - 11'(SCALE), {1'b0, y} - 11'(SCALE));
    pix_on = text_on || shadow_on;
    pix_rgb = text_on ? TEXT_RGB : shadow_on ? SHADOW_RGB : 6'b0;
  end
`else
  always_comb begin
    text_on = active && visible && lit({1'b0, x}, {1'b0, y});
    pix_on = text_on;
    pix_rgb = text_on ? TEXT_RGB : 6'b0;
  end
`endif

  assign busy = state == FALL || state == REVEAL;

  // start outranks a coincident frame tick; mode values map directly onto states
  always_comb begin
    state_n = state;
    base_y_n = base_y;
    reveal_n = reveal_cnt;
    visible_n = visible;
    frame_n = frame_cnt;
    done_n = 1'b0;
    step = {1'b0, base_y} + 11'(FALL_STEP);
    wrap = frame_cnt == (state == REVEAL ? FW'(REVEAL_FRAMES - 1) : FW'(BLINK_FRAMES - 1));
    if (start) begin
      state_n = state_t'(mode);
      base_y_n = mode == 2'd1 ? 10'd0 : 10'(TARGET_Y);
      reveal_n = mode == 2'd2 ? '0 : RW'(TOTAL);
      visible_n = 1'b1;
      frame_n = '0;
    end else if (next_frame && state == FALL) begin
      done_n = step >= 11'(TARGET_Y);
      base_y_n = done_n ? 10'(TARGET_Y) : step[9:0];
      state_n = done_n ? IDLE : FALL;
    end else if (next_frame && state == REVEAL) begin
      frame_n = wrap ? '0 : frame_cnt + 1'b1;
      reveal_n = reveal_cnt + RW'(wrap);
      done_n = wrap && reveal_cnt == RW'(TOTAL - 1);
      state_n = done_n ? IDLE : REVEAL;
    end else if (next_frame && state == BLINK) begin
      frame_n = wrap ? '0 : frame_cnt + 1'b1;
      visible_n = visible ^ wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base_y <= 10'(TARGET_Y);
      reveal_cnt <= RW'(TOTAL);
      visible <= 1'b1;
      frame_cnt <= '0;
      done <= 1'b0;
      draw <= 1'b0;
      rgb <= 6'b0;
    end else begin
      state <= state_n;
      base_y <= base_y_n;
      reveal_cnt <= reveal_n;
      visible <= visible_n;
      frame_cnt <= frame_n;
      done <= done_n;
      draw <= pix_on;
      rgb <= pix_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL; i++) chars[i] <= 5'd0;
    end else if (wr_en && int'(wr_line) < NUM_LINES && int'(wr_col) < LINE_LEN) begin
      chars[IW'(int'(wr_line) * LINE_LEN + int'(wr_col))] <= wr_char;
    end
  end
endmodule

// File: tb/tb_text_overlay_anim.sv
// tb_text_overlay_anim: randomized bench for text_overlay_anim against a frame-count reference model.
module tb_text_overlay_anim;
  localparam int NL = 2, LL = 12, S = 2, GAP = 4, TX = 224, TY = 336;
  localparam int FS = 4, RF = 4, BF = 30, TOTAL = NL * LL;
  localparam logic [63:0] FONT [11] = '{64'h0, 64'hC6C6C6D6FEEEC600, 64'h386CC6FEC6C6C600,
    64'h7E18181818181800, 64'hFEC0C0FCC0C0FE00, 64'hFCC6C6FCD8CCC600, 64'hC0C0C0C0C0C0FE00,
    64'h7CC6C6C6C6C67C00, 64'hC6E6F6DECEC6C600, 64'h7CC6C0CEC6C67E00, 64'h7E18181818187E00};

  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_n = 1, active = 0, next_frame = 0, wr_en = 0, start = 0;
  logic [9:0] x = 0, y = 0;
  logic [1:0] wr_line = 0, mode = 0;
  logic [3:0] wr_col = 0;
  logic [4:0] wr_char = 0;
  logic busy, done, draw;
  logic [5:0] rgb;

  text_overlay_anim #(.NUM_LINES(NL), .LINE_LEN(LL), .SCALE(S), .LINE_GAP(GAP), .TEXT_X(TX),
    .TARGET_Y(TY), .FALL_STEP(FS), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF), .TEXT_COLOR(6'b111111)
  ) dut (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .next_frame(next_frame),
    .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char), .mode(mode),
    .start(start), .busy(busy), .done(done), .draw(draw), .rgb(rgb));

  int checks = 0, passed = 0, done_seen = 0;
  bit armed = 0;
  // model: animation is a pure function of the mode and frames elapsed since start
  int m_mode = 0, m_f = 0;
  int mbuf [TOTAL];
  bit e_draw = 0, e_done = 0;
  logic [5:0] e_rgb = 0;

  function automatic int imin(int a, int b);
    return a < b ? a : b;
  endfunction

  function automatic logic [5:0] ilv(logic [5:0] c);
    return {c[5], c[3], c[1], c[4], c[2], c[0]};
  endfunction

  function automatic bit m_busy();
    return (m_mode == 1 && m_f * FS < TY) || (m_mode == 2 && m_f / RF < TOTAL);
  endfunction

  function automatic bit lit(int px, int py);
    int base, rev, top, off, idx, c;
    base = m_mode == 1 ? imin(m_f * FS, TY) : TY;
    rev = m_mode == 2 ? imin(m_f / RF, TOTAL) : TOTAL;
    if (m_mode == 3 && (m_f / BF) % 2 == 1) return 0;
    off = px - TX;
    if (off < 0 || off >= LL * 8 * S) return 0;
    for (int k = 0; k < NL; k++) begin
      top = base + k * (8 * S + GAP);
      if (top + 8 * S - 1 <= 1023 && py >= top && py < top + 8 * S) begin
        idx = k * LL + off / (8 * S);
        c = mbuf[idx];
        if (idx >= rev || c > 10) return 0;
        return FONT[c][63 - ((py - top) / S % 8) * 8 - (off / S) % 8];
      end
    end
    return 0;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic step_model();
    bit t, sh;
    t = active && lit(int'(x), int'(y));
    sh = 0;
`ifdef TEXT_OVERLAY_SHADOW_EN
    sh = active && !t && lit(int'(x) - S, int'(y) - S);
`endif
    e_draw = t || sh;
    e_rgb = t ? ilv(6'b111111) : sh ? ilv(6'b010101) : 6'b0;
    e_done = 0;
    if (start) begin
      m_mode = int'(mode);
      m_f = 0;
    end else if (next_frame) begin
      if (m_busy()) begin
        m_f++;
        e_done = !m_busy();
      end else if (m_mode == 3) m_f++;
    end
    if (wr_en && int'(wr_line) < NL && int'(wr_col) < LL) mbuf[int'(wr_line) * LL + int'(wr_col)] = int'(wr_char);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_mode = 0;
      m_f = 0;
      foreach (mbuf[i]) mbuf[i] = 0;
      e_draw = 0;
      e_rgb = 0;
      e_done = 0;
    end
    if (armed) begin
      chk("draw", int'(draw), int'(e_draw));
      chk("rgb", int'(rgb), int'(e_rgb));
      chk("busy", int'(busy), int'(m_busy()));
      chk("done", int'(done), int'(e_done));
    end
    if (done) done_seen++;
    if (rst_n) step_model();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_pix();
    x = 10'(200 + $urandom_range(0, 240));
    y = $urandom_range(0, 1) ? 10'(330 + $urandom_range(0, 45)) : 10'($urandom_range(0, 420));
    active = $urandom_range(0, 7) != 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      rnd_pix();
      cyc();
    end
  endtask

  task automatic frames(int n);
    repeat (n) begin
      next_frame = 1;
      rnd_pix();
      cyc();
      next_frame = 0;
      idle(3);
    end
  endtask

  task automatic wr(int l, int c, int ch);
    wr_en = 1;
    wr_line = 2'(l);
    wr_col = 4'(c);
    wr_char = 5'(ch);
    cyc();
    wr_en = 0;
  endtask

  task automatic go(int m);
    mode = 2'(m);
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic scan(string name, int px, int py, int exp);
    x = 10'(px);
    y = 10'(py);
    active = 1;
    cyc();
    chk(name, int'(draw), exp);
  endtask

  initial begin
    int d0;
    int word [8] = '{1, 2, 3, 4, 5, 6, 7, 7};
    #2 rst_n = 0;
    armed = 1;
    repeat (3) cyc();
    chk("rst_draw", int'(draw), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1;
    cyc();
    for (int c = 0; c < 8; c++) wr(0, c, word[c]);
    for (int c = 8; c < LL; c++) wr(0, c, int'($urandom_range(0, 31)));
    wr(1, 0, 0);
    wr(1, 1, 0);
    for (int c = 2; c < LL - 1; c++) wr(1, c, int'($urandom_range(0, 12)));
    wr(1, LL - 1, 1);
    scan("w_origin", 224, 336, 1);
    chk("w_origin_rgb", int'(rgb), 6'b111111);
    scan("w_col1", 225, 336, 1);
    scan("w_col2_gap", 228, 336, 0);
    idle(300);

    wr(0, 13, 1);
    wr(0, 12, 1);
    wr(2, 0, 1);
    scan("oob_col13", 240, 356, 0);
    scan("oob_col12", 224, 356, 0);

    d0 = done_seen;
    go(1);
    frames(25);
    scan("fall_at_100", 224, 100, 1);
    chk("fall_busy", int'(busy), 1);
    go(1);
    scan("abort_moved", 224, 100, 0);
    scan("abort_top0", 224, 0, 1);
    frames(83);
    chk("fall_busy_83", int'(busy), 1);
    next_frame = 1;
    cyc();
    next_frame = 0;
    chk("fall_done", int'(done), 1);
    chk("fall_busy_end", int'(busy), 0);
    idle(2);
    chk("fall_done_once", done_seen - d0, 1);
    scan("fall_landed", 224, 336, 1);

    go(2);
    scan("rev_start", 224, 336, 0);
    frames(3);
    scan("rev_3", 224, 336, 0);
    frames(1);
    scan("rev_4", 224, 336, 1);
    frames(91);
    scan("rev_c23_hidden", 400, 356, 0);
    chk("rev_busy", int'(busy), 1);
    next_frame = 1;
    cyc();
    next_frame = 0;
    chk("rev_done", int'(done), 1);
    scan("rev_c23_shown", 400, 356, 1);

    go(3);
    frames(29);
    scan("blink_29", 224, 336, 1);
    frames(1);
    scan("blink_30", 224, 336, 0);
    frames(29);
    scan("blink_59", 224, 336, 0);
    frames(1);
    scan("blink_60", 224, 336, 1);

    mode = 2'd1;
    start = 1;
    next_frame = 1;
    cyc();
    start = 0;
    next_frame = 0;
    scan("start_wins", 224, 0, 1);

    repeat (4000) begin
      start = $urandom_range(0, 299) == 0;
      mode = 2'($urandom_range(0, 3));
      next_frame = $urandom_range(0, 3) == 0;
      wr_en = $urandom_range(0, 19) == 0;
      wr_line = 2'($urandom_range(0, 3));
      wr_col = 4'($urandom_range(0, 15));
      wr_char = 5'($urandom_range(0, 31));
      rnd_pix();
      cyc();
      start = 0;
      next_frame = 0;
      wr_en = 0;
    end

    go(0);
    for (int c = 0; c < 8; c++) wr(0, c, word[c]);
    go(2);
    frames(10);
    scan("pre_rst_draw", 224, 336, 1);
    rst_n = 0;
    #1;
    chk("async_draw", int'(draw), 0);
    chk("async_busy", int'(busy), 0);
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    scan("rst_cleared", 224, 336, 0);
    scan("rst_cleared_l1", 400, 356, 0);
    idle(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
